id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register feeding the execute stage of the 5-stage MIPS32 pipeline. It latches decode-stage control and operands, inserts bubbles on load-use hazards and on branch/jump flushes, and freezes on a global hold. It also produces the registered forwarding selects `forwardAE`/`forwardBE` that execute consumes, one cycle ahead of their use.

---
 rtl/mips_pipe_pkg.sv | 57 +++++
 rtl/hazard_detect.sv | 36 +++
 rtl/id_ex_pipe_reg.sv | 147 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared encodings, ID/EX register layout and forwarding helper
package mips_pipe_pkg;

    // Forwarding select encodings steering the execute-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // ALU operation classes produced by decode
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Contents of the ID/EX register bank; a bubble is the all-zero value
    typedef struct packed {
        logic        valid;
        logic        mem_to_reg;
        logic        reg_write;
        logic        jump;
        logic        branch;
        logic        mem_write;
        logic        mem_read;
        logic        alu_src;
        logic        reg_dst;
        logic [1:0]  alu_op;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] signed_offset;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
    } id_ex_t;

    // The instruction now in ID/EX is newer than the one in EX/MEM, so it wins
    function automatic logic [1:0] fwd_select(
        input logic       idex_writes,
        input logic [4:0] idex_dest,
        input logic       exmem_writes,
        input logic [4:0] exmem_dest,
        input logic [4:0] src
    );
        if (idex_writes && idex_dest != REG_ZERO && idex_dest == src)
            return FWD_MEM;
        else if (exmem_writes && exmem_dest != REG_ZERO && exmem_dest == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use detection, stall request and next forwarding selects
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic       valid,
    input  logic       mem_read,
    input  logic       reg_write,
    input  logic       reg_dst,
    input  logic [4:0] rd1,
    input  logic [4:0] rd2,
    input  logic [4:0] rs_in,
    input  logic [4:0] rt_in,
    input  logic       ex_mem_reg_write,
    input  logic [4:0] ex_mem_rd,
    input  logic       flush,
    input  logic       hold,
    output logic       lu,
    output logic       stall,
    output logic [1:0] fwd_a_next,
    output logic [1:0] fwd_b_next
);

    logic [4:0] dest;

    // Hazard and forwarding decisions against the instruction held in ID/EX
    always_comb begin
        dest  = reg_dst ? rd2 : rd1;
        // A load's target is the rt field (rd1); it cannot be forwarded until MEM/WB
        lu    = valid && mem_read && (rd1 != REG_ZERO) && ((rd1 == rs_in) || (rd1 == rt_in));
        // A flush discards the dependent instruction and a hold freezes everything anyway
        stall = lu && !flush && !hold;
        fwd_a_next = fwd_select(valid && reg_write, dest, ex_mem_reg_write, ex_mem_rd, rs_in);
        fwd_b_next = fwd_select(valid && reg_write, dest, ex_mem_reg_write, ex_mem_rd, rt_in);
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with bubbles, freeze and registered forwarding
module id_ex_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   ex_mem_RegWrite,
    input  logic [4:0]             ex_mem_rd,
    input  logic                   MemtoReg_in,
    input  logic                   RegWrite_in,
    input  logic                   jump_in,
    input  logic                   branch_in,
    input  logic                   MemWrite_in,
    input  logic                   MemRead_in,
    input  logic                   ALUSrc_in,
    input  logic                   RegDst_in,
    input  logic [1:0]             ALUOp_in,
    input  logic [31:0]            NPC_in,
    input  logic [31:0]            a_in,
    input  logic [31:0]            b_in,
    input  logic [31:0]            signed_offset_in,
    input  logic [4:0]             rs_in,
    input  logic [4:0]             rt_in,
    input  logic [4:0]             rd_in,
    output logic                   MemtoReg_out,
    output logic                   RegWrite_out,
    output logic                   jump_out,
    output logic                   branch_out,
    output logic                   MemWrite_out,
    output logic                   MemRead_out,
    output logic                   ALUSrc_out,
    output logic                   RegDst_out,
    output logic [1:0]             ALUOp_out,
    output logic [31:0]            NPC_out,
    output logic [31:0]            a_out,
    output logic [31:0]            b_out,
    output logic [31:0]            signed_offset_out,
    output logic [4:0]             rd1_out,
    output logic [4:0]             rd2_out,
    output logic [4:0]             rs_out,
    output logic [4:0]             rt_out,
    output logic                   valid_out,
    output logic [1:0]             forwardAE,
    output logic [1:0]             forwardBE,
    output logic                   stall_out,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    id_ex_t     q;
    id_ex_t     d_load;
    logic       lu;
    logic [1:0] fwd_a_next;
    logic [1:0] fwd_b_next;

    hazard_detect u_hazard_detect (
        .valid            (q.valid),
        .mem_read         (q.mem_read),
        .reg_write        (q.reg_write),
        .reg_dst          (q.reg_dst),
        .rd1              (q.rd1),
        .rd2              (q.rd2),
        .rs_in            (rs_in),
        .rt_in            (rt_in),
        .ex_mem_reg_write (ex_mem_RegWrite),
        .ex_mem_rd        (ex_mem_rd),
        .flush            (flush),
        .hold             (hold),
        .lu               (lu),
        .stall            (stall_out),
        .fwd_a_next       (fwd_a_next),
        .fwd_b_next       (fwd_b_next)
    );

    // Assemble the value captured when decode advances normally
    always_comb begin
        d_load               = '0;
        d_load.valid         = 1'b1;
        d_load.mem_to_reg    = MemtoReg_in;
        d_load.reg_write     = RegWrite_in;
        d_load.jump          = jump_in;
        d_load.branch        = branch_in;
        d_load.mem_write     = MemWrite_in;
        d_load.mem_read      = MemRead_in;
        d_load.alu_src       = ALUSrc_in;
        d_load.reg_dst       = RegDst_in;
        d_load.alu_op        = ALUOp_in;
        d_load.npc           = NPC_in;
        d_load.a             = a_in;
        d_load.b             = b_in;
        d_load.signed_offset = signed_offset_in;
        d_load.rs            = rs_in;
        d_load.rt            = rt_in;
        d_load.rd1           = rt_in;
        d_load.rd2           = rd_in;
        d_load.fwd_a         = fwd_a_next;
        d_load.fwd_b         = fwd_b_next;
    end

    // Register update: reset, then flush bubble, then freeze, then load-use bubble, else load
    always_ff @(posedge clk) begin
        if (reset) begin
            q           <= '0;
            stall_count <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!hold) begin
            if (lu) begin
                q <= '0;
                if (stall_count != '1)
                    stall_count <= stall_count + CNT_ONE;
            end else begin
                q <= d_load;
            end
        end
    end

    // Outputs come straight from the register bank
    always_comb begin
        valid_out         = q.valid;
        MemtoReg_out      = q.mem_to_reg;
        RegWrite_out      = q.reg_write;
        jump_out          = q.jump;
        branch_out        = q.branch;
        MemWrite_out      = q.mem_write;
        MemRead_out       = q.mem_read;
        ALUSrc_out        = q.alu_src;
        RegDst_out        = q.reg_dst;
        ALUOp_out         = q.alu_op;
        NPC_out           = q.npc;
        a_out             = q.a;
        b_out             = q.b;
        signed_offset_out = q.signed_offset;
        rs_out            = q.rs;
        rt_out            = q.rt;
        rd1_out           = q.rd1;
        rd2_out           = q.rd2;
        forwardAE         = q.fwd_a;
        forwardBE         = q.fwd_b;
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed and randomized self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;
    import mips_pipe_pkg::*;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, hold, flush, ex_mem_RegWrite;
    logic [4:0] ex_mem_rd;
    logic MemtoReg_in, RegWrite_in, jump_in, branch_in, MemWrite_in, MemRead_in, ALUSrc_in, RegDst_in;
    logic [1:0] ALUOp_in;
    logic [31:0] NPC_in, a_in, b_in, signed_offset_in;
    logic [4:0] rs_in, rt_in, rd_in;

    logic MemtoReg_out, RegWrite_out, jump_out, branch_out, MemWrite_out, MemRead_out, ALUSrc_out, RegDst_out;
    logic [1:0] ALUOp_out;
    logic [31:0] NPC_out, a_out, b_out, signed_offset_out;
    logic [4:0] rd1_out, rd2_out, rs_out, rt_out;
    logic valid_out, stall_out;
    logic [1:0] forwardAE, forwardBE;
    logic [CW-1:0] stall_count;

    id_ex_pipe_reg #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_rd(ex_mem_rd),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .jump_in(jump_in), .branch_in(branch_in),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .ALUSrc_in(ALUSrc_in), .RegDst_in(RegDst_in),
        .ALUOp_in(ALUOp_in), .NPC_in(NPC_in), .a_in(a_in), .b_in(b_in), .signed_offset_in(signed_offset_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .jump_out(jump_out), .branch_out(branch_out),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out), .ALUSrc_out(ALUSrc_out), .RegDst_out(RegDst_out),
        .ALUOp_out(ALUOp_out), .NPC_out(NPC_out), .a_out(a_out), .b_out(b_out),
        .signed_offset_out(signed_offset_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
        .rs_out(rs_out), .rt_out(rt_out), .valid_out(valid_out),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stall_out(stall_out), .stall_count(stall_count)
    );

    // Architectural view of what the execute stage should see
    typedef struct packed {
        logic        valid;
        logic        memtoreg, regwrite, jump, branch, memwrite, memread, alusrc, regdst;
        logic [1:0]  aluop;
        logic [31:0] npc, a, b, off;
        logic [4:0]  rs, rt, rd1, rd2;
        logic [1:0]  fa, fb;
    } st_t;

    st_t m;
    int  m_cnt;
    int  n_chk = 0;
    int  n_err = 0;
    logic obs_stall;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic st_t observed();
        st_t s;
        s = '{valid_out, MemtoReg_out, RegWrite_out, jump_out, branch_out, MemWrite_out, MemRead_out,
              ALUSrc_out, RegDst_out, ALUOp_out, NPC_out, a_out, b_out, signed_offset_out,
              rs_out, rt_out, rd1_out, rd2_out, forwardAE, forwardBE};
        return s;
    endfunction

    // Which stage supplies register src to the next execute
    function automatic logic [1:0] source_of(input logic [4:0] src);
        logic [4:0] writes_to;
        writes_to = m.regdst ? m.rd2 : m.rd1;
        if (m.valid && m.regwrite && writes_to != 0 && writes_to == src) return 2'b10;
        if (ex_mem_RegWrite && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit load_use();
        return m.valid && m.memread && m.rd1 != 0 && (m.rd1 == rs_in || m.rd1 == rt_in);
    endfunction

    task automatic step();
        st_t nxt;
        int  cnt_nxt;
        bit  exp_stall;
        #1;
        exp_stall = load_use() && !flush && !hold;
        obs_stall = stall_out;
        check("stall_out", stall_out, exp_stall);
        nxt     = m;
        cnt_nxt = m_cnt;
        if (reset) begin
            nxt = '0; cnt_nxt = 0;
        end else if (flush) begin
            nxt = '0;
        end else if (hold) begin
            nxt = m;
        end else if (load_use()) begin
            nxt = '0;
            if (m_cnt < CNT_MAX) cnt_nxt = m_cnt + 1;
        end else begin
            nxt = '{1'b1, MemtoReg_in, RegWrite_in, jump_in, branch_in, MemWrite_in, MemRead_in,
                    ALUSrc_in, RegDst_in, ALUOp_in, NPC_in, a_in, b_in, signed_offset_in,
                    rs_in, rt_in, rt_in, rd_in, source_of(rs_in), source_of(rt_in)};
        end
        @(posedge clk);
        m     = nxt;
        m_cnt = cnt_nxt;
        #1;
        check("state", observed(), m);
        check("stall_count", stall_count, m_cnt);
    endtask

    function automatic logic [4:0] pick_reg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
    endfunction

    task automatic rand_instr();
        {MemtoReg_in, RegWrite_in, jump_in, branch_in, MemWrite_in, ALUSrc_in, RegDst_in} = 7'($urandom);
        MemRead_in = $urandom_range(0, 1);
        ALUOp_in = 2'($urandom);
        NPC_in = $urandom; a_in = $urandom; b_in = $urandom; signed_offset_in = $urandom;
        rs_in = pick_reg(); rt_in = pick_reg(); rd_in = pick_reg();
        ex_mem_RegWrite = $urandom_range(0, 1);
        ex_mem_rd = pick_reg();
    endtask

    // Directed instruction: random payload, chosen hazard-relevant fields
    task automatic instr(input bit mem_read, input bit reg_write, input bit reg_dst,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        rand_instr();
        reset = 0; hold = 0; flush = 0;
        ex_mem_RegWrite = 0; ex_mem_rd = 0;
        MemRead_in = mem_read; RegWrite_in = reg_write; RegDst_in = reg_dst;
        ALUOp_in = mem_read ? ALUOP_ADD : ALUOP_RTYPE;
        rs_in = rs; rt_in = rt; rd_in = rd;
    endtask

    st_t snap;
    int  cnt_snap;

    initial begin
        m = '0; m_cnt = 0;
        reset = 1; hold = 0; flush = 0;
        rand_instr();
        @(posedge clk); #1;

        // Reset with random inputs, then first load
        for (int i = 0; i < 2; i++) begin
            rand_instr(); reset = 1; hold = $urandom_range(0, 1); flush = $urandom_range(0, 1);
            step();
        end
        check("reset_valid", valid_out, 1'b0);
        check("reset_count", stall_count, '0);

        // lw $5 then dependent add
        instr(1, 1, 0, 5'd1, 5'd5, 5'd0);
        step();
        check("first_load_valid", valid_out, 1'b1);
        instr(0, 1, 1, 5'd5, 5'd6, 5'd7);
        step();
        check("lu_stall", obs_stall, 1'b1);
        check("lu_bubble", valid_out, 1'b0);
        ex_mem_RegWrite = 1; ex_mem_rd = 5'd5;
        step();
        check("lu_stall_once", obs_stall, 1'b0);
        check("lu_fwdA", forwardAE, FWD_WB);
        check("lu_count", stall_count, 4'd1);

        // Back-to-back ALU ops, then writes to $0
        instr(0, 1, 1, 5'd1, 5'd2, 5'd3);
        step();
        instr(0, 1, 1, 5'd3, 5'd3, 5'd8);
        step();
        check("b2b_fwdA", forwardAE, FWD_MEM);
        check("b2b_fwdB", forwardBE, FWD_MEM);
        instr(0, 1, 1, 5'd1, 5'd2, 5'd0);
        step();
        instr(0, 1, 1, 5'd0, 5'd0, 5'd9);
        ex_mem_RegWrite = 1; ex_mem_rd = 5'd0;
        step();
        check("zero_fwdA", forwardAE, FWD_RF);
        check("zero_fwdB", forwardBE, FWD_RF);

        // Both ID/EX and EX/MEM write $4
        instr(0, 1, 1, 5'd1, 5'd2, 5'd4);
        step();
        instr(0, 1, 1, 5'd4, 5'd4, 5'd10);
        ex_mem_RegWrite = 1; ex_mem_rd = 5'd4;
        step();
        check("dual_fwdA", forwardAE, FWD_MEM);
        instr(0, 0, 1, 5'd1, 5'd2, 5'd4);
        step();
        instr(0, 1, 1, 5'd4, 5'd2, 5'd11);
        ex_mem_RegWrite = 1; ex_mem_rd = 5'd4;
        step();
        check("dual_wb_fwdA", forwardAE, FWD_WB);

        // Flush during load-use
        instr(1, 1, 0, 5'd2, 5'd5, 5'd0);
        step();
        cnt_snap = m_cnt;
        instr(0, 1, 1, 5'd5, 5'd6, 5'd7);
        flush = 1;
        step();
        check("flush_stall", obs_stall, 1'b0);
        check("flush_valid", valid_out, 1'b0);
        check("flush_count", stall_count, CW'(cnt_snap));

        // Hold 3 cycles over a pending load-use
        instr(1, 1, 0, 5'd2, 5'd5, 5'd0);
        step();
        snap = m;
        for (int i = 0; i < 3; i++) begin
            instr(0, 1, 1, 5'd5, 5'd5, 5'd7);
            hold = 1;
            step();
            check("hold_stall", obs_stall, 1'b0);
            check("hold_frozen", observed(), snap);
        end

        // Drive the counter into saturation
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            instr(1, 1, 0, 5'd3, 5'd5, 5'd0);
            step();
            instr(0, 1, 1, 5'd5, 5'd1, 5'd2);
            step();
        end
        check("sat_count", stall_count, 4'hF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_instr();
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) begin
                rs_in = m.rd1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
